mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Sequences the CPU's single external memory port between the fetch stage (instruction reads) and the memory stage (loads/stores driven by MemRead/MemWrite/Mmask from the decoder). It arbitrates, registers each transaction, generates byte enables and store-data lanes, and sign/zero-extends load data. It produces stall signals the pipeline uses to freeze the stages whose access is outstanding. A timeout counter aborts hung transactions.

Parameters:
ADDR_W, 32, byte address width
TIMEOUT, 64, cycles without mem_ack before abort (≥2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
if_req  in  1  fetch read request, held until if_valid
if_addr  in  ADDR_W  fetch address (word aligned)
if_rdata  out  32  instruction word
if_valid  out  1  one-cycle pulse: if_rdata valid
if_stall  out  1  if_req && !if_valid
d_read  in  1  load request (MemRead)
d_write  in  1  store request (MemWrite); d_read && d_write is illegal
d_addr  in  ADDR_W  data byte address (ALU result)
d_wdata  in  32  store data (rs2)
d_mask  in  mem_mask_t  MEM_BYTE/MEM_HALF/MEM_WORD/MEM_UBYTE/MEM_UHALF
d_rdata  out  32  extended load data
d_valid  out  1  one-cycle pulse: data access complete
d_stall  out  1  (d_read||d_write) && !d_valid
d_err  out  1  one-cycle pulse with d_valid: misaligned or timeout
mem_addr  out  ADDR_W  word-aligned bus address (addr[1:0]=0)
mem_wdata  out  32  lane-replicated store data
mem_byteen  out  4  byte enables
mem_read  out  1  bus read strobe, held until ack
mem_write  out  1  bus write strobe, held until ack
mem_rdata  in  32  bus read data, valid with mem_ack
mem_ack  in  1  one-cycle transaction complete

Behaviour:
- Reset (async): state IDLE; timer 0; all outputs 0 (mem_*, *_valid, d_err, rdata regs); stalls follow their combinational definitions.
- FSM states: IDLE, FETCH, DATA.
- IDLE: data request has priority over fetch (older instruction). If d_read||d_write: check alignment; misaligned (HALF/UHALF with addr[0]=1, WORD with addr[1:0]≠0) -> no bus cycle, next cycle pulse d_valid+d_err, d_rdata=0, stay IDLE. Else latch addr/byteen/wdata/mask, go DATA. Else if if_req: latch if_addr, go FETCH.
- FETCH/DATA: mem_read/mem_write asserted from registers, stable until ack. Timer increments each cycle in state, clears on entry.
- On mem_ack: register result, pulse if_valid or d_valid next cycle, return IDLE; new arbitration happens in IDLE (one idle bubble between transactions, minimum latency request→valid = 2 cycles with ack in first busy cycle).
- Timer reaching TIMEOUT-1 without ack: deassert strobes, pulse valid with rdata 0; d_err=1 for DATA, FETCH returns 0x00000013 (NOP) without error flag. Late ack in IDLE is ignored.
- Byte enables: BYTE/UBYTE -> 4'b0001<<addr[1:0]; HALF/UHALF -> addr[1] ? 4'b1100 : 4'b0011; WORD -> 4'b1111; fetch read -> 4'b1111.
- Store data: BYTE -> {4{wdata[7:0]}}; HALF -> {2{wdata[15:0]}}; WORD -> wdata.
- Load: select byte/half by latched addr[1:0]; BYTE/HALF sign-extend, UBYTE/UHALF zero-extend, WORD pass.
- Requester dropping its request mid-transaction (pipeline flush): transaction completes on bus; result discarded, no valid pulse.
- Simultaneous ack and timeout expiry: ack wins, normal result.
- Reset mid-transaction: strobes drop asynchronously; no valid pulse afterward.

Test Plan:
- Fetch only: if_req, if_addr=0x100, ack after 3 cycles with 0x00500093 -> mem_read=1, mem_addr=0x100, byteen=1111 for 3 cycles; if_valid one cycle, if_rdata=0x00500093; if_stall high until then.
- Contention: if_req and d_read (WORD, 0x2000) same cycle -> DATA served first, d_valid, then IDLE bubble, then FETCH; if_stall held throughout.
- LB at 0x2003, mem_rdata=0x80FF_0000 -> byteen=1000, d_rdata=0xFFFFFF80; repeat LBU -> 0x00000080; LH at 0x2002 -> 0xFFFF80FF.
- SB 0x1001 wdata=0x12345678 -> mem_write=1, mem_addr=0x1000, byteen=0010, mem_wdata=0x78787878; SH 0x1002 -> byteen=1100, wdata=0x56785678.
- Misaligned LW at 0x1002 -> no mem strobe, d_valid+d_err pulse next cycle, d_rdata=0. No ack for TIMEOUT=64 on load -> strobe drops after 64 cycles, d_valid+d_err; fetch timeout -> if_rdata=0x00000013, no error.
- Assert rst mid-DATA -> mem_read drops same cycle, no d_valid later; after release, new fetch proceeds normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the CPU's single external memory port between instruction fetch and
// the memory stage (loads/stores). One transaction is in flight at a time. A
// data request wins over a fetch because it belongs to the older instruction.
// Each request is latched, driven on the bus until mem_ack arrives, and its
// result is returned as a one-cycle valid pulse. A timer aborts a hung bus
// cycle after TIMEOUT cycles.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   if_req/if_addr             fetch read request (held until if_valid)
//   if_rdata/if_valid/if_stall instruction word, completion pulse, stall
//   d_read/d_write/d_addr      load/store request and byte address
//   d_wdata/d_mask             store data, access size/signedness
//   d_rdata/d_valid/d_err      extended load data, completion pulse, error
//   d_stall                    data stage stall
//   mem_addr/mem_wdata         word-aligned bus address, lane-replicated data
//   mem_byteen                 bus byte enables
//   mem_read/mem_write         bus strobes, held until mem_ack
//   mem_rdata/mem_ack          bus read data, one-cycle completion
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [2:0]        d_mask,
    output logic [31:0]       d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_byteen,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    // Access size encoding (funct3 of RISC-V loads/stores).
    localparam logic [2:0] MEM_BYTE  = 3'b000;
    localparam logic [2:0] MEM_HALF  = 3'b001;
    localparam logic [2:0] MEM_WORD  = 3'b010;
    localparam logic [2:0] MEM_UBYTE = 3'b100;
    localparam logic [2:0] MEM_UHALF = 3'b101;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    localparam int TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_p1;
    logic [3:0]         byteen_p1;
    logic [31:0]        wdata_p1;
    logic [2:0]         mask_p1;
    logic               wr_p1;
    logic [TIMER_W-1:0] timer_p1;

    logic d_req, d_take, f_take, d_misaligned, expired;

    function automatic logic is_misaligned(input logic [1:0] ofs, input logic [2:0] mask);
        case (mask)
            MEM_BYTE, MEM_UBYTE: return 1'b0;
            MEM_HALF, MEM_UHALF: return ofs[0];
            default:             return ofs != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] lane_enables(input logic [1:0] ofs, input logic [2:0] mask);
        case (mask)
            MEM_BYTE, MEM_UBYTE: return 4'b0001 << ofs;
            MEM_HALF, MEM_UHALF: return ofs[1] ? 4'b1100 : 4'b0011;
            default:             return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [31:0] wdata, input logic [2:0] mask);
        case (mask)
            MEM_BYTE, MEM_UBYTE: return {4{wdata[7:0]}};
            MEM_HALF, MEM_UHALF: return {2{wdata[15:0]}};
            default:             return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] ofs,
                                                input logic [2:0] mask);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        b = word[{ofs, 3'b000} +: 8];
        h = ofs[1] ? word[31:16] : word[15:0];
        case (mask)
            MEM_BYTE:  r = 32'(b);
            MEM_UBYTE: r = {24'd0, b};
            MEM_HALF:  r = 32'(h);
            MEM_UHALF: r = {16'd0, h};
            default:   r = word;
        endcase
        return r;
    endfunction

    assign d_req        = d_read | d_write;
    // A requester whose valid is pulsing still holds its old request this
    // cycle; it must not be accepted a second time.
    assign d_take       = d_req && !d_valid;
    assign f_take       = if_req && !if_valid;
    assign d_misaligned = is_misaligned(d_addr[1:0], d_mask);
    assign expired      = (timer_p1 == TIMER_LAST);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (d_take) begin
                    if (!d_misaligned) state_d = DATA;
                end else if (f_take) begin
                    state_d = FETCH;
                end
            end
            FETCH, DATA: begin
                if (mem_ack || expired) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: strobes decode from state so reset drops them immediately
    always_comb begin
        mem_read   = (state_q == FETCH) || (state_q == DATA && !wr_p1);
        mem_write  = (state_q == DATA) && wr_p1;
        mem_addr   = {addr_p1[ADDR_W-1:2], 2'b00};
        mem_byteen = byteen_p1;
        mem_wdata  = wdata_p1;
        if_stall   = if_req && !if_valid;
        d_stall    = d_req && !d_valid;
    end

    // Stage p1: latched transaction, timer and returned results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_p1   <= '0;
            byteen_p1 <= '0;
            wdata_p1  <= '0;
            mask_p1   <= '0;
            wr_p1     <= 1'b0;
            timer_p1  <= '0;
            if_rdata  <= '0;
            if_valid  <= 1'b0;
            d_rdata   <= '0;
            d_valid   <= 1'b0;
            d_err     <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            d_err    <= 1'b0;
            timer_p1 <= (state_q == IDLE) ? '0 : timer_p1 + 1'b1;
            case (state_q)
                IDLE: begin
                    if (d_take) begin
                        if (d_misaligned) begin
                            d_valid <= 1'b1;
                            d_err   <= 1'b1;
                            d_rdata <= '0;
                        end else begin
                            addr_p1   <= d_addr;
                            byteen_p1 <= lane_enables(d_addr[1:0], d_mask);
                            wdata_p1  <= store_lanes(d_wdata, d_mask);
                            mask_p1   <= d_mask;
                            wr_p1     <= d_write;
                        end
                    end else if (f_take) begin
                        addr_p1   <= if_addr;
                        byteen_p1 <= 4'b1111;
                        wdata_p1  <= '0;
                        mask_p1   <= MEM_WORD;
                        wr_p1     <= 1'b0;
                    end
                end
                // A dropped request (flush) lets the bus cycle finish silently.
                FETCH: begin
                    if (if_req && (mem_ack || expired)) begin
                        if_valid <= 1'b1;
                        if_rdata <= mem_ack ? mem_rdata : NOP_INSN;
                    end
                end
                DATA: begin
                    if (d_req && mem_ack) begin
                        d_valid <= 1'b1;
                        d_rdata <= wr_p1 ? 32'd0 : load_extend(mem_rdata, addr_p1[1:0], mask_p1);
                    end else if (d_req && expired) begin
                        d_valid <= 1'b1;
                        d_err   <= 1'b1;
                        d_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam logic [2:0] MEM_BYTE  = 3'b000;
    localparam logic [2:0] MEM_HALF  = 3'b001;
    localparam logic [2:0] MEM_WORD  = 3'b010;
    localparam logic [2:0] MEM_UBYTE = 3'b100;
    localparam logic [2:0] MEM_UHALF = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid, if_stall;
    logic        d_read, d_write;
    logic [31:0] d_addr, d_wdata;
    logic [2:0]  d_mask;
    logic [31:0] d_rdata;
    logic        d_valid, d_stall, d_err;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_byteen;
    logic        mem_read, mem_write;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int errors = 0;
    int checks = 0;
    int n;

    mem_port_arbiter #(.ADDR_W(32), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_mask(d_mask), .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
        .d_err(d_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_byteen(mem_byteen), .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] mask,
                           input logic [31:0] bus, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_data);
        d_read = 1'b1; d_addr = addr; d_mask = mask;
        tick();
        check({tag, "_rd"}, 32'(mem_read), 32'd1);
        check({tag, "_addr"}, mem_addr, exp_addr);
        check({tag, "_be"}, 32'(mem_byteen), 32'(exp_be));
        mem_ack = 1'b1; mem_rdata = bus;
        tick();
        mem_ack = 1'b0;
        check({tag, "_vld"}, {d_valid, d_err}, 32'b10);
        check({tag, "_data"}, d_rdata, exp_data);
        d_read = 1'b0;
        tick();
    endtask

    task automatic do_store(input string tag, input logic [31:0] addr, input logic [2:0] mask,
                            input logic [31:0] wdata, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        d_write = 1'b1; d_addr = addr; d_mask = mask; d_wdata = wdata;
        tick();
        check({tag, "_strb"}, {mem_write, mem_read}, 32'b10);
        check({tag, "_addr"}, mem_addr, exp_addr);
        check({tag, "_be"}, 32'(mem_byteen), 32'(exp_be));
        check({tag, "_wdata"}, mem_wdata, exp_wdata);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check({tag, "_vld"}, {d_valid, d_err}, 32'b10);
        d_write = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; if_req = 0; if_addr = 0; d_read = 0; d_write = 0;
        d_addr = 0; d_wdata = 0; d_mask = MEM_WORD; mem_rdata = 0; mem_ack = 0;
        tick(); tick();
        check("rst_strobes", {mem_read, mem_write}, 32'd0);
        check("rst_valids", {if_valid, d_valid, d_err}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_be", 32'(mem_byteen), 32'd0);
        check("rst_rdata", if_rdata | d_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // Fetch only, ack on third busy cycle
        if_req = 1; if_addr = 32'h100;
        #1 check("f_stall0", 32'(if_stall), 32'd1);
        tick();
        check("f_rd1", 32'(mem_read), 32'd1);
        check("f_addr", mem_addr, 32'h100);
        check("f_be", 32'(mem_byteen), 32'hF);
        tick();
        check("f_rd2", 32'(mem_read), 32'd1);
        tick();
        check("f_rd3", {mem_read, if_stall}, 32'b11);
        mem_ack = 1; mem_rdata = 32'h0050_0093;
        tick();
        mem_ack = 0;
        check("f_valid", {if_valid, if_stall, mem_read}, 32'b100);
        check("f_data", if_rdata, 32'h0050_0093);
        if_req = 0;
        tick();
        check("f_pulse", 32'(if_valid), 32'd0);

        // Contention: data first, bubble, then fetch
        if_req = 1; if_addr = 32'h104; d_read = 1; d_addr = 32'h2000; d_mask = MEM_WORD;
        tick();
        check("c_data_strb", {mem_read, mem_write}, 32'b10);
        check("c_data_addr", mem_addr, 32'h2000);
        mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 0;
        check("c_dvalid", {d_valid, d_err, mem_read, if_stall}, 32'b1001);
        check("c_drdata", d_rdata, 32'hDEAD_BEEF);
        d_read = 0;
        tick();
        check("c_fetch", {mem_read, d_valid, if_stall}, 32'b101);
        check("c_fetch_addr", mem_addr, 32'h104);
        mem_ack = 1; mem_rdata = 32'h0000_0033;
        tick();
        mem_ack = 0;
        check("c_ivalid", {if_valid, if_stall}, 32'b10);
        check("c_irdata", if_rdata, 32'h0000_0033);
        if_req = 0;
        tick();

        // Loads with extension
        do_load("lb",  32'h2003, MEM_BYTE,  32'h80FF_0000, 32'h2000, 4'b1000, 32'hFFFF_FF80);
        do_load("lbu", 32'h2003, MEM_UBYTE, 32'h80FF_0000, 32'h2000, 4'b1000, 32'h0000_0080);
        do_load("lh",  32'h2002, MEM_HALF,  32'h80FF_0000, 32'h2000, 4'b1100, 32'hFFFF_80FF);
        do_load("lhu", 32'h2002, MEM_UHALF, 32'h80FF_0000, 32'h2000, 4'b1100, 32'h0000_80FF);
        do_load("lb2", 32'h2002, MEM_BYTE,  32'h80FF_0000, 32'h2000, 4'b0100, 32'hFFFF_FFFF);
        do_load("lh0", 32'h2000, MEM_HALF,  32'h1234_7FFE, 32'h2000, 4'b0011, 32'h0000_7FFE);

        // Stores
        do_store("sb", 32'h1001, MEM_BYTE, 32'h1234_5678, 32'h1000, 4'b0010, 32'h7878_7878);
        do_store("sh", 32'h1002, MEM_HALF, 32'h1234_5678, 32'h1000, 4'b1100, 32'h5678_5678);
        do_store("sw", 32'h1004, MEM_WORD, 32'h1234_5678, 32'h1004, 4'b1111, 32'h1234_5678);

        // Misaligned load: no bus cycle, error pulse next cycle
        d_read = 1; d_addr = 32'h1002; d_mask = MEM_WORD;
        #1 check("mis_stall", 32'(d_stall), 32'd1);
        tick();
        check("mis_strb", {mem_read, mem_write}, 32'd0);
        check("mis_pulse", {d_valid, d_err, d_stall}, 32'b110);
        check("mis_rdata", d_rdata, 32'd0);
        d_read = 0;
        tick();
        check("mis_after", {d_valid, d_err, mem_read}, 32'd0);

        // Load timeout
        d_read = 1; d_addr = 32'h3000; d_mask = MEM_WORD;
        tick();
        n = 0;
        while (mem_read && n < 200) begin n++; tick(); end
        check("to_d_cycles", 32'(n), 32'd64);
        check("to_d_pulse", {d_valid, d_err}, 32'b11);
        check("to_d_rdata", d_rdata, 32'd0);
        d_read = 0;
        mem_ack = 1; mem_rdata = 32'h5555_5555;
        tick();
        mem_ack = 0;
        check("late_ack", {d_valid, if_valid, mem_read}, 32'd0);

        // Fetch timeout returns NOP without error
        if_req = 1; if_addr = 32'h200;
        tick();
        n = 0;
        while (mem_read && n < 200) begin n++; tick(); end
        check("to_f_cycles", 32'(n), 32'd64);
        check("to_f_pulse", {if_valid, d_err}, 32'b10);
        check("to_f_nop", if_rdata, 32'h0000_0013);
        if_req = 0;
        tick();

        // Ack in the same cycle as timeout expiry: ack wins
        if_req = 1; if_addr = 32'h300;
        tick();
        for (int i = 0; i < 63; i++) tick();
        check("ack_to_rd", 32'(mem_read), 32'd1);
        mem_ack = 1; mem_rdata = 32'h1111_1111;
        tick();
        mem_ack = 0;
        check("ack_to_vld", 32'(if_valid), 32'd1);
        check("ack_to_data", if_rdata, 32'h1111_1111);
        if_req = 0;
        tick();

        // Request dropped mid-transaction: no valid pulse
        d_read = 1; d_addr = 32'h2000; d_mask = MEM_WORD;
        tick();
        d_read = 0;
        mem_ack = 1; mem_rdata = 32'h2222_2222;
        tick();
        mem_ack = 0;
        check("flush", {d_valid, d_err, mem_read}, 32'd0);
        tick();

        // Reset mid-DATA
        d_read = 1; d_addr = 32'h2004; d_mask = MEM_WORD;
        tick();
        check("rst_mid_rd", 32'(mem_read), 32'd1);
        rst = 1;
        #1 check("rst_mid_drop", 32'(mem_read), 32'd0);
        tick();
        rst = 0; d_read = 0;
        tick();
        check("rst_mid_novld", {d_valid, d_err, mem_read}, 32'd0);
        if_req = 1; if_addr = 32'h400;
        tick();
        check("post_rst_f", 32'(mem_read), 32'd1);
        check("post_rst_addr", mem_addr, 32'h400);
        mem_ack = 1; mem_rdata = 32'h0000_ABCD;
        tick();
        mem_ack = 0;
        check("post_rst_vld", 32'(if_valid), 32'd1);
        check("post_rst_data", if_rdata, 32'h0000_ABCD);
        if_req = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
